// File: rtl/vpu_line_fetch_if.sv
// CPU register port, timing pulses, memory read master and cache write port of the line fetcher.
interface vpu_line_fetch_if #(
  parameter int CADDR_W = 6
);
  logic [1:0]         AD;
  logic [7:0]         DI;
  logic [7:0]         DO;
  logic               rw;
  logic               cs;
  logic               irq;
  logic               line_start;
  logic               frame_start;
  logic               mreq;
  logic               mgnt;
  logic [15:0]        maddr;
  logic               mrd;
  logic [7:0]         mdata;
  logic               mvalid;
  logic               cwe;
  logic [CADDR_W-1:0] caddr;
  logic [7:0]         cdata;

  modport master (
    input  AD, DI, rw, cs, line_start, frame_start, mgnt, mdata, mvalid,
    output DO, irq, mreq, maddr, mrd, cwe, caddr, cdata
  );

  modport slave (
    output AD, DI, rw, cs, line_start, frame_start, mgnt, mdata, mvalid,
    input  DO, irq, mreq, maddr, mrd, cwe, caddr, cdata
  );
endinterface

// File: rtl/vpu_line_fetch.sv
// Scanline fetcher: copies LINE_BYTES bytes from memory at the line pointer into the video cache.
// state  | meaning
// IDLE   | waiting for line_start with EN set
// REQ    | requesting the bus, waiting for grant
// RD     | issuing one read strobe at CUR if still granted
// WAIT   | one read outstanding, waiting for mvalid
// DONE   | advancing line pointer by STRIDE, raising IRQ
module vpu_line_fetch #(
  parameter int LINE_BYTES = 64,
  parameter int CADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  vpu_line_fetch_if.master  bus
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WAIT, S_DONE} state_t;

  localparam logic [CADDR_W-1:0] IDX_LAST = CADDR_W'(LINE_BYTES - 1);

  state_t             state_q, state_d;
  logic [15:0]        base_q, base_d, lptr_q, lptr_d, cur_q, cur_d;
  logic [7:0]         stride_q, stride_d, do_q, do_d;
  logic [CADDR_W-1:0] idx_q, idx_d;
  logic               ien_q, ien_d, en_q, en_d, irq_q, irq_d, ovr_q, ovr_d;
  logic               busy, irq_set, ovr_set, cpu_wr, cpu_rd;
  logic               mreq_c, mrd_c, cwe_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      lptr_q   <= '0;
      cur_q    <= '0;
      stride_q <= '0;
      do_q     <= '0;
      idx_q    <= '0;
      ien_q    <= 1'b0;
      en_q     <= 1'b0;
      irq_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      lptr_q   <= lptr_d;
      cur_q    <= cur_d;
      stride_q <= stride_d;
      do_q     <= do_d;
      idx_q    <= idx_d;
      ien_q    <= ien_d;
      en_q     <= en_d;
      irq_q    <= irq_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    lptr_d   = lptr_q;
    cur_d    = cur_q;
    stride_d = stride_q;
    do_d     = do_q;
    idx_d    = idx_q;
    ien_d    = ien_q;
    en_d     = en_q;
    irq_d    = irq_q;
    ovr_d    = ovr_q;
    mreq_c   = 1'b0;
    mrd_c    = 1'b0;
    cwe_c    = 1'b0;
    irq_set  = 1'b0;
    busy     = (state_q != S_IDLE);
    ovr_set  = bus.line_start & busy;
    cpu_wr   = bus.cs & ~bus.rw;
    cpu_rd   = bus.cs & bus.rw;

    unique case (state_q)
      S_IDLE: begin
        if (bus.line_start && en_q) begin
          cur_d   = lptr_q;
          idx_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mreq_c = 1'b1;
        if (bus.mgnt) state_d = S_RD;
      end
      S_RD: begin
        mreq_c = 1'b1;
        if (bus.mgnt) begin
          mrd_c   = 1'b1;
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        mreq_c = 1'b1;
        if (bus.mvalid) begin
          cwe_c   = 1'b1;
          cur_d   = cur_q + 16'd1;
          idx_d   = idx_q + CADDR_W'(1);
          state_d = (idx_q == IDX_LAST) ? S_DONE : S_RD;
        end
      end
      S_DONE: begin
        lptr_d  = lptr_q + {8'h00, stride_q};
        irq_set = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Frame reload overrides the end-of-line stride advance.
    if (bus.frame_start) lptr_d = base_q;

    if (cpu_wr) begin
      unique case (bus.AD)
        2'd0: base_d[15:8] = bus.DI;
        2'd1: base_d[7:0]  = bus.DI;
        2'd2: stride_d     = bus.DI;
        2'd3: {ien_d, en_d} = bus.DI[6:5];
        default: ;
      endcase
    end

    if (cpu_rd) begin
      unique case (bus.AD)
        2'd0: do_d = base_q[15:8];
        2'd1: do_d = base_q[7:0];
        2'd2: do_d = stride_q;
        2'd3: do_d = {irq_q, ien_q, en_q, ovr_q, busy, 3'b000};
        default: ;
      endcase
      if (bus.AD == 2'd3) begin
        irq_d = 1'b0;
        ovr_d = 1'b0;
      end
    end

    if (irq_set) irq_d = 1'b1;
    if (ovr_set) ovr_d = 1'b1;
  end

  assign bus.DO    = do_q;
  assign bus.irq   = irq_q & ien_q;
  assign bus.mreq  = mreq_c;
  assign bus.mrd   = mrd_c;
  assign bus.cwe   = cwe_c;
  assign bus.maddr = cur_q;
  assign bus.caddr = idx_q;
  assign bus.cdata = bus.mdata;
endmodule

// File: tb/tb_vpu_line_fetch.sv
// Directed bench for vpu_line_fetch: memory model returns addr[7:0] one cycle after each mrd.
module tb_vpu_line_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vpu_line_fetch_if #(.CADDR_W(6)) bus ();
  vpu_line_fetch #(.LINE_BYTES(64), .CADDR_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [15:0] rd_q[$];
  logic [7:0]  ca_q[$];
  logic [7:0]  cd_q[$];
  int both_cnt = 0;
  int bad_cnt  = 0;
  logic        rd_seen = 1'b0;
  logic [15:0] rd_a = '0;

  // Memory responder: a strobe seen in cycle k yields mvalid/mdata in cycle k+1.
  initial begin
    bus.mvalid = 1'b0;
    bus.mdata  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus.mvalid = rd_seen;
      bus.mdata  = rd_a[7:0];
    end
  end

  initial forever begin
    @(negedge clk);
    rd_seen = bus.mrd;
    rd_a    = bus.maddr;
    if (bus.cwe) begin
      ca_q.push_back(8'(bus.caddr));
      cd_q.push_back(bus.cdata);
    end
    if (bus.mrd) rd_q.push_back(bus.maddr);
    if (bus.mrd && bus.cwe) both_cnt++;
    if ((bus.mrd || bus.cwe) && !bus.mreq) bad_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.rw = 1'b0; bus.AD = a; bus.DI = d;
    tick();
    bus.cs = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    bus.cs = 1'b1; bus.rw = 1'b1; bus.AD = a;
    tick();
    bus.cs = 1'b0;
    d = bus.DO;
  endtask

  task automatic pulse_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic start_line();
    rd_q.delete(); ca_q.delete(); cd_q.delete();
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int k = 0;
    while (ca_q.size() < n && k < 400) begin
      tick();
      k++;
    end
    checks++;
    if (ca_q.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d bytes, required %0d", tag, ca_q.size(), n);
    end
  endtask

  task automatic finish_line(input string tag);
    wait_bytes(64, tag);
    tick();
  endtask

  task automatic check_fill(input logic [15:0] base, input string tag);
    logic [15:0] ea;
    checks++;
    if (ca_q.size() != 64 || rd_q.size() != 64) begin
      errors++;
      $display("FAIL %s count: cwe %0d mrd %0d, required 64", tag, ca_q.size(), rd_q.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        ea = base + 16'(i);
        checks++;
        if (rd_q[i] !== ea || ca_q[i] !== 8'(i) || cd_q[i] !== ea[7:0]) begin
          errors++;
          $display("FAIL %s byte %0d: maddr %h caddr %0d cdata %h, required %h %0d %h",
                   tag, i, rd_q[i], ca_q[i], cd_q[i], ea, i, ea[7:0]);
        end
      end
    end
    checks++;
    if (both_cnt !== 0 || bad_cnt !== 0) begin
      errors++;
      $display("FAIL %s strobes: both=%0d outside_req=%0d, required 0 0", tag, both_cnt, bad_cnt);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (3) tick();
    checks++;
    if ({bus.mreq, bus.mrd, bus.cwe, bus.irq} !== 4'b0000 || bus.DO !== 8'h00) begin
      errors++;
      $display("FAIL reset outputs: mreq/mrd/cwe/irq %b DO %h, required 0000 00",
               {bus.mreq, bus.mrd, bus.cwe, bus.irq}, bus.DO);
    end
    rst = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      cpu_read(2'(a), d);
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("FAIL reset reg %0d: got %h, required 00", a, d);
      end
    end
  endtask

  task automatic test_basic_fill();
    logic [7:0] d;
    cpu_write(2'd0, 8'h10);
    cpu_write(2'd1, 8'h00);
    cpu_write(2'd2, 8'h40);
    cpu_write(2'd3, 8'h20);
    pulse_frame();
    start_line();
    finish_line("basic");
    check_fill(16'h1000, "basic");
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL basic irq with IEN=0: got %b, required 0", bus.irq);
    end
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'hA0) begin errors++; $display("FAIL basic ctrl: got %h, required a0", d); end
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'h20) begin errors++; $display("FAIL basic ctrl clear: got %h, required 20", d); end
  endtask

  task automatic test_stride();
    logic [7:0] d;
    start_line();
    finish_line("stride");
    check_fill(16'h1040, "stride");
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'hA0) begin errors++; $display("FAIL stride ctrl: got %h, required a0", d); end
  endtask

  task automatic test_grant_loss();
    logic [7:0] d;
    int n0;
    pulse_frame();
    start_line();
    wait_bytes(10, "gap");
    bus.mgnt = 1'b0;
    n0 = rd_q.size();
    repeat (5) tick();
    checks++;
    if (rd_q.size() !== n0 || n0 !== 10) begin
      errors++;
      $display("FAIL gap mrd: strobes %0d -> %0d, required 10 -> 10", n0, rd_q.size());
    end
    bus.mgnt = 1'b1;
    finish_line("gap");
    checks++;
    if (rd_q.size() > 10 && rd_q[10] !== 16'h100A) begin
      errors++;
      $display("FAIL gap resume: maddr %h, required 100a", rd_q[10]);
    end
    check_fill(16'h1000, "gap");
    cpu_read(2'd3, d);
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    pulse_frame();
    start_line();
    wait_bytes(5, "ovr");
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    finish_line("ovr");
    check_fill(16'h1000, "ovr");
    repeat (3) tick();
    checks++;
    if (bus.mreq !== 1'b0) begin errors++; $display("FAIL ovr restart: mreq %b, required 0", bus.mreq); end
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'hB0) begin errors++; $display("FAIL ovr ctrl: got %h, required b0", d); end
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'h20) begin errors++; $display("FAIL ovr clear: got %h, required 20", d); end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    cpu_write(2'd0, 8'hFF);
    cpu_write(2'd1, 8'hF0);
    cpu_write(2'd2, 8'hFF);
    pulse_frame();
    start_line();
    finish_line("wrap");
    checks++;
    if (rd_q.size() < 17 || rd_q[15] !== 16'hFFFF || rd_q[16] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap maddr: entries 15/16 wrong or missing, required ffff 0000");
    end
    check_fill(16'hFFF0, "wrap");
    cpu_read(2'd3, d);
    start_line();
    wait_bytes(1, "wrap_lptr");
    checks++;
    if (rd_q.size() < 1 || rd_q[0] !== 16'h00EF) begin
      errors++;
      $display("FAIL wrap lptr: first maddr wrong or missing, required 00ef");
    end
    finish_line("wrap_lptr");
    cpu_read(2'd3, d);
  endtask

  task automatic test_irq_collision();
    logic [7:0] d;
    cpu_write(2'd3, 8'h60);
    start_line();
    wait_bytes(64, "coll");
    checks++;
    if (bus.mreq !== 1'b0) begin errors++; $display("FAIL coll done mreq: got %b, required 0", bus.mreq); end
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'h68) begin errors++; $display("FAIL coll DO: got %h, required 68", d); end
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL coll irq: got %b, required 1", bus.irq); end
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'hE0 || bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL coll clear: ctrl %h irq %b, required e0 0", d, bus.irq);
    end
  endtask

  task automatic test_en_clear();
    logic [7:0] d;
    start_line();
    wait_bytes(5, "enclr");
    cpu_write(2'd3, 8'h00);
    finish_line("enclr");
    checks++;
    if (ca_q.size() !== 64) begin errors++; $display("FAIL enclr bytes: got %0d, required 64", ca_q.size()); end
    start_line();
    repeat (4) tick();
    checks++;
    if (bus.mreq !== 1'b0 || rd_q.size() !== 0) begin
      errors++;
      $display("FAIL enclr restart: mreq %b strobes %0d, required 0 0", bus.mreq, rd_q.size());
    end
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'h80) begin errors++; $display("FAIL enclr ctrl: got %h, required 80", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    cpu_write(2'd3, 8'h60);
    pulse_frame();
    start_line();
    wait_bytes(30, "rstmid");
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.mreq, bus.mrd, bus.irq} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid outputs: mreq/mrd/irq %b, required 000", {bus.mreq, bus.mrd, bus.irq});
    end
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (ca_q.size() !== 30) begin errors++; $display("FAIL rstmid late mvalid: bytes %0d, required 30", ca_q.size()); end
    for (int a = 0; a < 4; a++) begin
      cpu_read(2'(a), d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL rstmid reg %0d: got %h, required 00", a, d); end
    end
    start_line();
    repeat (4) tick();
    checks++;
    if (bus.mreq !== 1'b0 || rd_q.size() !== 0) begin
      errors++;
      $display("FAIL rstmid en0: mreq %b strobes %0d, required 0 0", bus.mreq, rd_q.size());
    end
    cpu_write(2'd3, 8'h20);
    start_line();
    wait_bytes(1, "rstmid_lptr");
    checks++;
    if (rd_q.size() < 1 || rd_q[0] !== 16'h0000) begin
      errors++;
      $display("FAIL rstmid lptr: first maddr wrong or missing, required 0000");
    end
    finish_line("rstmid_lptr");
  endtask

  initial begin
    bus.cs = 1'b0; bus.rw = 1'b0; bus.AD = 2'd0; bus.DI = 8'h00;
    bus.line_start = 1'b0; bus.frame_start = 1'b0; bus.mgnt = 1'b1;
    test_reset();
    test_basic_fill();
    test_stride();
    test_grant_loss();
    test_overrun();
    test_wrap();
    test_irq_collision();
    test_en_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
